// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply controller: op codes and controller states.
package hilo_pkg;

    localparam logic [2:0] OP_MULT = 3'b001;
    localparam logic [2:0] OP_MTHI = 3'b010;
    localparam logic [2:0] OP_MTLO = 3'b011;
    localparam logic [2:0] OP_MFHI = 3'b100;
    localparam logic [2:0] OP_MFLO = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_mult_ctrl_if.sv
// Bundle between control unit / multiplier side (master) and the HI/LO controller (slave).
interface hilo_mult_ctrl_if #(
    parameter int WIDTH = 32
);

    logic             op_valid;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             op_ready;
    logic             stall;
    logic             mult_start;
    logic [WIDTH-1:0] mult_a;
    logic [WIDTH-1:0] mult_b;
    logic             mult_done;
    logic [WIDTH-1:0] mult_hi;
    logic [WIDTH-1:0] mult_lo;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] rdata;
    logic             rdata_valid;
    logic             busy;
    logic             timeout_err;

    modport master (
        output op_valid, op_code, rs_val, rt_val,
        output mult_done, mult_hi, mult_lo,
        input  op_ready, stall, mult_start, mult_a, mult_b,
        input  hi_q, lo_q, rdata, rdata_valid, busy, timeout_err
    );

    modport slave (
        input  op_valid, op_code, rs_val, rt_val,
        input  mult_done, mult_hi, mult_lo,
        output op_ready, stall, mult_start, mult_a, mult_b,
        output hi_q, lo_q, rdata, rdata_valid, busy, timeout_err
    );

endinterface

// File: rtl/hilo_mult_ctrl.sv
// Owns the architectural HI/LO pair: launches Booth multiplies, captures their products,
// and serves MTHI/MTLO/MFHI/MFLO while interlocking them against an in-flight multiply.
module hilo_mult_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic            clk,
    input  logic            reset,
    hilo_mult_ctrl_if.slave bus
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    wait_cnt;
    logic             done_d;
    logic             done_rise;
    logic             accept;
    logic             load_product;
    logic             start;
    logic             timeout;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] rdata_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             rdata_valid_r;

    // Only a fresh rise of done counts, so a level left high by the previous op is ignored.
    assign done_rise = bus.mult_done && !done_d;
    assign accept    = bus.op_valid && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start        = 1'b0;
        timeout      = 1'b0;
        load_product = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && (bus.op_code == OP_MULT)) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                start   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    load_product = 1'b1;
                    state_d      = IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The counter restarts at LAUNCH and saturates, so it never wraps inside WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            done_d   <= 1'b0;
        end else begin
            done_d <= bus.mult_done;
            if (state_q == LAUNCH) begin
                wait_cnt <= '0;
            end else if ((state_q == WAIT) && (wait_cnt != CNT_LAST)) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r          <= '0;
            lo_r          <= '0;
            rdata_r       <= '0;
            rdata_valid_r <= 1'b0;
            a_r           <= '0;
            b_r           <= '0;
        end else begin
            rdata_valid_r <= 1'b0;
            if (accept) begin
                case (bus.op_code)
                    OP_MULT: begin
                        a_r <= bus.rs_val;
                        b_r <= bus.rt_val;
                    end
                    OP_MTHI: hi_r <= bus.rs_val;
                    OP_MTLO: lo_r <= bus.rs_val;
                    OP_MFHI: begin
                        rdata_r       <= hi_r;
                        rdata_valid_r <= 1'b1;
                    end
                    OP_MFLO: begin
                        rdata_r       <= lo_r;
                        rdata_valid_r <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            if (load_product) begin
                hi_r <= bus.mult_hi;
                lo_r <= bus.mult_lo;
            end
        end
    end

    assign bus.op_ready    = (state_q == IDLE);
    assign bus.stall       = bus.op_valid && (state_q != IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.mult_start  = start;
    assign bus.timeout_err = timeout;
    assign bus.mult_a      = a_r;
    assign bus.mult_b      = b_r;
    assign bus.hi_q        = hi_r;
    assign bus.lo_q        = lo_r;
    assign bus.rdata       = rdata_r;
    assign bus.rdata_valid = rdata_valid_r;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Self-checking bench for hilo_mult_ctrl: behavioural multiplier, cycle-age reference model,
// and directed HI/LO scenarios with hand-computed expectations.
module tb_hilo_mult_ctrl;
    import hilo_pkg::*;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hilo_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

    hilo_mult_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks   = 0;
    int   n_errors   = 0;
    int   mul_delay  = 33;
    int   stale_hold = 0;
    logic model_on   = 1'b0;

    int cyc       = 0;
    int start_cnt = 0;
    int busy_cnt  = 0;
    int stall_cnt = 0;
    int rv_cnt    = 0;
    int tmo_cnt   = 0;
    int start_cyc = 0;
    int tmo_cyc   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural multiplier: done rises mul_delay cycles after the start pulse, never if negative.
    initial begin : mult_model
        logic        s_rst;
        logic        s_start;
        logic        running;
        int          mcnt;
        logic [63:0] prod;
        bus.mult_done = 1'b0;
        bus.mult_hi   = '0;
        bus.mult_lo   = '0;
        running       = 1'b0;
        mcnt          = 0;
        prod          = '0;
        forever begin
            @(negedge clk);
            s_rst   = reset;
            s_start = bus.mult_start;
            @(posedge clk);
            #2;
            if (s_rst) begin
                bus.mult_done = 1'b0;
                bus.mult_hi   = '0;
                bus.mult_lo   = '0;
                running       = 1'b0;
            end else if (s_start || running) begin
                if (s_start) begin
                    running = 1'b1;
                    mcnt    = 1;
                    prod    = $signed({{32{bus.mult_a[31]}}, bus.mult_a}) *
                              $signed({{32{bus.mult_b[31]}}, bus.mult_b});
                end else begin
                    mcnt++;
                end
                if (mcnt >= stale_hold) bus.mult_done = 1'b0;
                if (mcnt == mul_delay) begin
                    bus.mult_hi   = prod[63:32];
                    bus.mult_lo   = prod[31:0];
                    bus.mult_done = 1'b1;
                    running       = 1'b0;
                end
            end
        end
    end

    // Reference model: age counts cycles since a MULT was accepted (-1 when nothing is in flight).
    initial begin : compare
        int          age;
        logic [31:0] m_hi, m_lo, m_rdata, m_a, m_b;
        logic        m_rv, m_prev_done, rise;
        logic [63:0] p;
        age = -1;
        m_hi = '0; m_lo = '0; m_rdata = '0; m_a = '0; m_b = '0;
        m_rv = 1'b0; m_prev_done = 1'b0;
        forever begin
            @(negedge clk);
            rise = bus.mult_done && !m_prev_done && (age >= 2);
            if (model_on) begin
                checkOutput("busy",        32'(bus.busy),        32'(age >= 1));
                checkOutput("op_ready",    32'(bus.op_ready),    32'(age < 1));
                checkOutput("stall",       32'(bus.stall),       32'(bus.op_valid && (age >= 1)));
                checkOutput("mult_start",  32'(bus.mult_start),  32'(age == 1));
                checkOutput("timeout_err", 32'(bus.timeout_err), 32'((age == TIMEOUT + 1) && !rise));
                checkOutput("rdata_valid", 32'(bus.rdata_valid), 32'(m_rv));
                checkOutput("hi_q",        bus.hi_q,             m_hi);
                checkOutput("lo_q",        bus.lo_q,             m_lo);
                checkOutput("rdata",       bus.rdata,            m_rdata);
                checkOutput("mult_a",      bus.mult_a,           m_a);
                checkOutput("mult_b",      bus.mult_b,           m_b);
            end
            m_rv = 1'b0;
            if (reset) begin
                age = -1;
                m_hi = '0; m_lo = '0; m_rdata = '0; m_a = '0; m_b = '0;
                m_prev_done = 1'b0;
            end else begin
                if (age == -1) begin
                    if (bus.op_valid) begin
                        case (bus.op_code)
                            OP_MULT: begin m_a = bus.rs_val; m_b = bus.rt_val; age = 1; end
                            OP_MTHI: m_hi = bus.rs_val;
                            OP_MTLO: m_lo = bus.rs_val;
                            OP_MFHI: begin m_rdata = m_hi; m_rv = 1'b1; end
                            OP_MFLO: begin m_rdata = m_lo; m_rv = 1'b1; end
                            default: ;
                        endcase
                    end
                end else if (rise) begin
                    p    = $signed({{32{m_a[31]}}, m_a}) * $signed({{32{m_b[31]}}, m_b});
                    m_hi = p[63:32];
                    m_lo = p[31:0];
                    age  = -1;
                end else if (age == TIMEOUT + 1) begin
                    age = -1;
                end else begin
                    age++;
                end
                m_prev_done = bus.mult_done;
            end
        end
    end

    // Pulse and cycle counters used by the literal latency checks.
    initial begin : counters
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.mult_start)  begin start_cnt++; start_cyc = cyc; end
            if (bus.timeout_err) begin tmo_cnt++;   tmo_cyc   = cyc; end
            if (bus.busy)        busy_cnt++;
            if (bus.stall)       stall_cnt++;
            if (bus.rdata_valid) rv_cnt++;
        end
    end

    task automatic applyStimulus(input logic [2:0] code, input logic [31:0] rs, input logic [31:0] rt);
        int waited = 0;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        @(negedge clk);
        while (!bus.op_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("op_accept", 32'(bus.op_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.op_code  = 3'b000;
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_idle", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int s_start, s_busy, s_stall, s_rv, s_tmo;
        reset        = 1'b1;
        bus.op_valid = 1'b0;
        bus.op_code  = 3'b000;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        model_on = 1'b1;

        @(negedge clk);
        checkOutput("reset_hi",    bus.hi_q,              32'h0);
        checkOutput("reset_busy",  32'(bus.busy),         32'd0);
        checkOutput("reset_ready", 32'(bus.op_ready),     32'd1);

        $display("[TB] MULT 7 * -3");
        mul_delay = 33; stale_hold = 0;
        s_start = start_cnt; s_busy = busy_cnt;
        applyStimulus(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        waitIdle(100);
        checkOutput("mult_hi_lit",   bus.hi_q,                32'hFFFF_FFFF);
        checkOutput("mult_lo_lit",   bus.lo_q,                32'hFFFF_FFEB);
        checkOutput("start_pulses",  32'(start_cnt - s_start), 32'd1);
        checkOutput("busy_cycles",   32'(busy_cnt - s_busy),   32'd34);

        $display("[TB] MTHI then MFHI");
        applyStimulus(OP_MTHI, 32'hDEAD_0000, 32'h0);
        @(negedge clk);
        checkOutput("mthi_hi", bus.hi_q, 32'hDEAD_0000);
        s_rv = rv_cnt;
        applyStimulus(OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("mfhi_rdata", bus.rdata,              32'hDEAD_0000);
        checkOutput("mfhi_valid", 32'(bus.rdata_valid),   32'd1);
        @(negedge clk);
        checkOutput("mfhi_valid_drop", 32'(bus.rdata_valid), 32'd0);
        @(posedge clk);
        checkOutput("mfhi_pulses", 32'(rv_cnt - s_rv), 32'd1);

        $display("[TB] NOP codes");
        applyStimulus(3'b111, 32'h1234_5678, 32'h0);
        applyStimulus(3'b000, 32'h1234_5678, 32'h0);
        @(negedge clk);
        checkOutput("nop_hi", bus.hi_q, 32'hDEAD_0000);
        checkOutput("nop_lo", bus.lo_q, 32'hFFFF_FFEB);

        $display("[TB] MFLO during MULT 5 * 9");
        s_stall = stall_cnt;
        applyStimulus(OP_MULT, 32'd5, 32'd9);
        applyStimulus(OP_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("mflo_rdata", bus.rdata,            32'h0000_002D);
        checkOutput("mflo_valid", 32'(bus.rdata_valid), 32'd1);
        checkOutput("mflo_hi",    bus.hi_q,             32'h0);
        @(posedge clk);
        checkOutput("stall_cycles", 32'(stall_cnt - s_stall), 32'd33);

        $display("[TB] stale done from previous MULT");
        @(negedge clk);
        checkOutput("stale_done_pre", 32'(bus.mult_done), 32'd1);
        mul_delay = 20; stale_hold = 5;
        s_busy = busy_cnt;
        applyStimulus(OP_MULT, 32'h0001_0000, 32'h0001_0000);
        waitIdle(100);
        checkOutput("stale_busy_cycles", 32'(busy_cnt - s_busy), 32'd21);
        checkOutput("stale_hi",          bus.hi_q,               32'h0000_0001);
        checkOutput("stale_lo",          bus.lo_q,               32'h0);

        $display("[TB] multiplier never finishes");
        mul_delay = -1; stale_hold = 0;
        s_tmo = tmo_cnt;
        applyStimulus(OP_MULT, 32'd3, 32'd4);
        waitIdle(100);
        checkOutput("tmo_pulses",  32'(tmo_cnt - s_tmo),     32'd1);
        checkOutput("tmo_latency", 32'(tmo_cyc - start_cyc), 32'(TIMEOUT));
        checkOutput("tmo_hi",      bus.hi_q,                 32'h0000_0001);
        checkOutput("tmo_lo",      bus.lo_q,                 32'h0);

        $display("[TB] reset mid-WAIT, then MULT 2 * 3");
        mul_delay = 33;
        applyStimulus(OP_MULT, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_hi",    bus.hi_q,             32'h0);
        checkOutput("rst_lo",    bus.lo_q,             32'h0);
        checkOutput("rst_rdata", bus.rdata,            32'h0);
        checkOutput("rst_a",     bus.mult_a,           32'h0);
        checkOutput("rst_busy",  32'(bus.busy),        32'd0);
        applyStimulus(OP_MULT, 32'd2, 32'd3);
        waitIdle(100);
        checkOutput("post_rst_lo", bus.lo_q, 32'd6);
        checkOutput("post_rst_hi", bus.hi_q, 32'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
